// File: rtl/adc_model_pkg.sv
// Shared types and constants for the multi-channel SAR ADC bench model.
// The optional oversampling feature is enabled with `define ADC_OVERSAMPLE_EN.
package adc_model_pkg;

    // Conversion sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        READ = 2'd2
    } state_e;

    // Largest honoured oversampling exponent (64 samples).
    localparam int OS_MAX    = 6;
    // Accumulator growth needed to sum 2**OS_MAX samples without overflow.
    localparam int ACC_EXTRA = 6;

    // Ceiling log2, usable in parameter/localparam expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage : adc_model_pkg

// File: rtl/adc_serial_shifter.sv
// One serial output line of the ADC model: parallel-load a frame of BITS bits,
// shift it out MSB-first one bit per enabled cycle into a registered output.
// done_o flags the cycle in which the final bit of the frame is being shifted.
module adc_serial_shifter
    import adc_model_pkg::*;
#(
    parameter int BITS = 64
) (
    input  logic            rd_sclk,
    input  logic            reset,
    input  logic            load_i,
    input  logic [BITS-1:0] data_i,
    input  logic            shift_i,
    input  logic            clear_i,
    output logic            bit_o,
    output logic            done_o
);

    localparam int CNT_W = clog2(BITS + 1);

    logic [BITS-1:0]  sr_q,  sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bit_q, bit_d;

    // Next-state: load beats shift beats clear; otherwise everything holds (pause).
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path infers a latch.
        sr_d  = sr_q;
        cnt_d = cnt_q;
        bit_d = bit_q;
        if (load_i) begin
            sr_d  = data_i;
            cnt_d = '0;
            bit_d = 1'b0;
        end else if (shift_i) begin
            bit_d = sr_q[BITS-1];
            sr_d  = sr_q << 1;
            cnt_d = cnt_q + CNT_W'(1);
        end else if (clear_i) begin
            bit_d = 1'b0;
        end
    end

    // State register for shift data, bit counter and the output bit.
    always_ff @(posedge rd_sclk or negedge reset) begin
        if (!reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
            bit_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
        end
    end

    // Outputs: registered line bit and end-of-frame strobe.
    always_comb begin
        bit_o  = bit_q;
        done_o = shift_i && (cnt_q == CNT_W'(BITS - 1));
    end

endmodule : adc_serial_shifter

// File: rtl/adc_multichan_model.sv
// Behavioural model of a simultaneous-sampling multi-channel SAR ADC.
// A convst rising edge captures all channels, busy covers the conversion time,
// then results shift out MSB-first on douta (lower channels) and doutb (upper).
// Define ADC_OVERSAMPLE_EN to average 2**os samples per conversion.
module adc_multichan_model
    import adc_model_pkg::*;
#(
    parameter int NCH         = 8,
    parameter int WIDTH       = 16,
    parameter int CONV_CYCLES = 12
) (
    input  logic                 rd_sclk,
    input  logic                 reset,
    input  logic                 convst,
    input  logic                 stby,
    input  logic [2:0]           os,
    input  logic [NCH*WIDTH-1:0] ain,
    input  logic                 cs,
    output logic                 busy,
    output logic                 douta,
    output logic                 doutb,
    output logic                 ovr
);

    localparam int HALF = NCH / 2;
    localparam int BITS = HALF * WIDTH;
    localparam int CC_W = clog2(CONV_CYCLES + 1);

    state_e           state_q, state_d;
    logic             convst_q;
    logic             edge_det;
    logic             start;
    logic             capture;
    logic             sub_last;
    logic             samp_last;
    logic             conv_done;
    logic             frame_done;
    logic             done_a, done_b;
    logic             bit_a,  bit_b;
    logic             shift_en;
    logic [CC_W-1:0]  sub_cnt_q, sub_cnt_d;
    logic [WIDTH-1:0] res_q [NCH];
    logic [WIDTH-1:0] res_d [NCH];
    logic             ovr_q, ovr_d;
    logic [BITS-1:0]  frame_a, frame_b;

    assign edge_det = convst & ~convst_q;
    assign start    = edge_det & stby;
    // A start edge is honoured everywhere except during a conversion.
    assign capture  = start && (state_q != CONV);
    assign sub_last = (sub_cnt_q == CC_W'(CONV_CYCLES - 1));

`ifdef ADC_OVERSAMPLE_EN
    localparam int ACC_W = WIDTH + ACC_EXTRA;

    logic [2:0]       os_q,   os_d;
    logic [OS_MAX:0]  samp_q, samp_d;
    logic [ACC_W-1:0] acc_q   [NCH];
    logic [ACC_W-1:0] acc_d   [NCH];
    logic [ACC_W-1:0] acc_sum [NCH];
    logic [OS_MAX:0]  samp_max;

    assign samp_max  = (OS_MAX + 1)'((1 << os_q) - 1);
    assign samp_last = (samp_q == samp_max);

    // Running per-channel sum including the word sampled this cycle.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            acc_sum[c] = acc_q[c] + ACC_W'(ain[c*WIDTH +: WIDTH]);
        end
    end

    // Oversampling bookkeeping: clamp os at the edge, count and sum sub-period samples.
    always_comb begin
        os_d   = os_q;
        samp_d = samp_q;
        acc_d  = acc_q;
        if (capture) begin
            os_d   = (os > 3'(OS_MAX)) ? 3'(OS_MAX) : os;
            samp_d = '0;
            for (int c = 0; c < NCH; c++) begin
                acc_d[c] = '0;
            end
        end else if (state_q == CONV && sub_last) begin
            samp_d = samp_q + (OS_MAX + 1)'(1);
            acc_d  = acc_sum;
        end
    end

    // Oversampling registers.
    always_ff @(posedge rd_sclk or negedge reset) begin
        if (!reset) begin
            os_q   <= '0;
            samp_q <= '0;
            for (int c = 0; c < NCH; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            os_q   <= os_d;
            samp_q <= samp_d;
            acc_q  <= acc_d;
        end
    end
`else
    logic unused_os;

    // Without oversampling a conversion is a single sub-period and os has no effect.
    assign samp_last = 1'b1;
    assign unused_os = ^os;
`endif

    assign conv_done  = (state_q == CONV) && sub_last && samp_last;
    assign frame_done = done_a & done_b;
    // The overrun edge takes precedence over shifting a bit.
    assign shift_en   = (state_q == READ) && !cs && !start;

    // Next-state logic for the IDLE -> CONV -> READ sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)      state_d = CONV;
            CONV:    if (conv_done)  state_d = READ;
            READ: begin
                if (start)           state_d = CONV;
                else if (frame_done) state_d = IDLE;
            end
            default:                 state_d = IDLE;
        endcase
    end

    // Datapath next-state: conversion timer, result capture and sticky overrun.
    always_comb begin
        sub_cnt_d = sub_cnt_q;
        res_d     = res_q;
        ovr_d     = ovr_q;
        if (capture) begin
            sub_cnt_d = '0;
`ifndef ADC_OVERSAMPLE_EN
            for (int c = 0; c < NCH; c++) begin
                res_d[c] = ain[c*WIDTH +: WIDTH];
            end
`endif
        end else if (state_q == CONV) begin
            if (sub_last) begin
                sub_cnt_d = '0;
`ifdef ADC_OVERSAMPLE_EN
                if (samp_last) begin
                    for (int c = 0; c < NCH; c++) begin
                        res_d[c] = WIDTH'(acc_sum[c] >> os_q);
                    end
                end
`endif
            end else begin
                sub_cnt_d = sub_cnt_q + CC_W'(1);
            end
        end
        if (start && state_q == READ) begin
            ovr_d = 1'b1;
        end
    end

    // Pack channel results into the two line frames, lowest channel at the MSB end.
    always_comb begin
        frame_a = '0;
        frame_b = '0;
        for (int i = 0; i < HALF; i++) begin
            frame_a[BITS-1-i*WIDTH -: WIDTH] = res_d[i];
            frame_b[BITS-1-i*WIDTH -: WIDTH] = res_d[HALF+i];
        end
    end

    // State register plus datapath registers.
    always_ff @(posedge rd_sclk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            convst_q  <= 1'b0;
            sub_cnt_q <= '0;
            ovr_q     <= 1'b0;
            // NOTE: result words are cleared on reset so a read before any conversion returns zeros.
            for (int c = 0; c < NCH; c++) begin
                res_q[c] <= '0;
            end
        end else begin
            state_q   <= state_d;
            convst_q  <= convst;
            sub_cnt_q <= sub_cnt_d;
            ovr_q     <= ovr_d;
            res_q     <= res_d;
        end
    end

    adc_serial_shifter #(.BITS(BITS)) u_shift_a (
        .rd_sclk (rd_sclk),
        .reset   (reset),
        .load_i  (conv_done),
        .data_i  (frame_a),
        .shift_i (shift_en),
        .clear_i (state_q != READ),
        .bit_o   (bit_a),
        .done_o  (done_a)
    );

    adc_serial_shifter #(.BITS(BITS)) u_shift_b (
        .rd_sclk (rd_sclk),
        .reset   (reset),
        .load_i  (conv_done),
        .data_i  (frame_b),
        .shift_i (shift_en),
        .clear_i (state_q != READ),
        .bit_o   (bit_b),
        .done_o  (done_b)
    );

    // Output decode from state and registered line bits.
    always_comb begin
        busy  = (state_q == CONV);
        douta = bit_a;
        doutb = bit_b;
        ovr   = ovr_q;
    end

endmodule : adc_multichan_model
